shifter_pipe: RTL
=================

# shifter_pipe

Parametrised, pipelined successor to the 16-bit combinational Shifter used by the ALU. It shifts or rotates a WIDTH-bit operand by a runtime amount in log2(WIDTH) registered stages, one conditional power-of-two shift per stage, with a valid/ready handshake on both sides. It sits between the decode/operand-fetch stage and the writeback mux on multi-cycle shift paths, sustaining one operation per cycle when the consumer is ready.

## Interface
- WIDTH, 16: operand width; power of two, minimum 4.
- SHW, $clog2(WIDTH): shift-amount width and pipeline depth; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- In_Valid  input  1  request valid.
- In_Ready  output  1  stage 0 can accept a request this cycle.
- Shift_In  input  WIDTH  operand.
- Shift_Val  input  SHW  shift amount, 0..WIDTH-1.
- Mode  input  2  00 SLL, 01 SRA, 10 SRL, 11 ROR.
- Out_Valid  output  1  result valid.
- Out_Ready  input  1  consumer accepts the result.
- Shift_Out  output  WIDTH  result.
- Out_Mode  output  2  Mode of the result, carried through the pipeline.

## Operation
- Pipeline of SHW stage registers. Each register holds data, remaining amount, mode and valid.
- Stage k (k=0..SHW-1) shifts its data by 2^k when bit k of the amount is set. Otherwise data passes unchanged.
- SLL fills with 0. SRL fills with 0. SRA fills with the operand MSB, captured at entry and carried per stage. ROR moves the bits shifted out back in at the MSB end.
- Shift_Val = 0 returns Shift_In unchanged in every mode.
- Global advance enable: adv = Out_Ready | ~Out_Valid. When adv=1, every stage loads from its predecessor and stage 0 loads the input. When adv=0, all stages hold.
- In_Ready = adv. A transfer occurs on In_Valid & In_Ready.
- A cycle with In_Valid=0 and adv=1 inserts a bubble: stage 0 valid is cleared.
- Shift_Out, Out_Mode and Out_Valid are driven directly from the last stage register.

## Timing
- Reset: all valid bits clear, data, amount and mode registers cleared to 0. Out_Valid=0, Shift_Out=0, Out_Mode=0. In_Ready=1 in the first cycle after reset.
- Latency: an input accepted at edge N appears with Out_Valid=1 after edge N+SHW-1. For WIDTH=16 that is 4 clock edges from acceptance to output register.
- Throughput: 1 result per cycle while Out_Ready=1.
- Backpressure: when Out_Valid=1 and Out_Ready=0, Shift_Out and Out_Mode stay stable, In_Ready=0, and no request is lost or duplicated.
- Out_Ready may be asserted while Out_Valid=0. The pipeline keeps advancing.
- Simultaneous output handshake and input handshake in the same cycle: both complete.
- rst asserted mid-operation: all in-flight requests are discarded and the next cycle matches the reset state.

## Configuration
- SHIFTER_ROR_EN defined: Mode 11 performs rotate-right.
- SHIFTER_ROR_EN undefined: the ROR wrap path is not built. Mode 11 behaves as a pass-through: the amount is forced to 0 at entry and Shift_Out equals Shift_In after the normal latency.

## Structure
- Package shifter_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {SLL, SRA, SRL, ROR}.
  - A stage-record struct typedef, parametrised through a localparam, or one declared per instance.
- Sub-module shifter_stage (parameters WIDTH and STEP = 2^k): combinational conditional shift by STEP, covering all four modes, with the register stage around it. shifter_pipe instantiates it SHW times using generate.

## Test plan
- WIDTH=16, SLL, 0x0001 by 1, 2, 3 and 15 → 0x0002, 0x0004, 0x0008, 0x8000, each SHW=4 cycles after acceptance.
- SRA 0x8000 by 1, 2, 3 → 0xC000, 0xE000, 0xF000. SRL 0x8000 by 3 → 0x1000. SRA 0x4000 by 2 → 0x1000.
- ROR with SHIFTER_ROR_EN: 0x0001 by 1 → 0x8000, 0x1234 by 4 → 0x4123. Without the macro: 0x1234 with Mode 11 by 4 → 0x1234.
- Back-to-back stream of 8 requests with Out_Ready held low for 3 cycles mid-stream → results appear in order, none dropped or duplicated, Shift_Out stable while stalled, In_Ready=0 during the stall.
- Assert rst with 3 requests in flight → Out_Valid=0 next cycle and no stale results afterwards. Repeat with WIDTH=32: SLL 0x1 by 31 → 0x80000000 after 5 cycles.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// SHIFTER_ROR_EN enables the rotate-right path for mode 11.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRA = 2'b01,
        SRL = 2'b10,
        ROR = 2'b11
    } shift_mode_t;

    localparam int MODE_W = 2;

    function automatic logic ror_enabled();
`ifdef SHIFTER_ROR_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One conditional power-of-two shift step plus its pipeline register.
// SHIFTER_ROR_EN selects whether the rotate wrap path exists.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  shift_mode_t      in_mode,
    input  logic             in_msb,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output shift_mode_t      out_mode,
    output logic             out_msb
);

    localparam int K = $clog2(STEP);

    typedef struct packed {
        logic             valid;
        logic             msb;
        shift_mode_t      mode;
        logic [SHW-1:0]   amt;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           r;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        if (in_amt[K]) begin
            unique case (in_mode)
                SLL: shifted = in_data << STEP;
                SRL: shifted = in_data >> STEP;
                // Fill comes from the operand MSB captured at entry
                SRA: shifted = {{STEP{in_msb}}, in_data[WIDTH-1:STEP]};
`ifdef SHIFTER_ROR_EN
                ROR: shifted = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
`else
                ROR: shifted = in_data;
`endif
                default: shifted = in_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (adv) begin
            r.valid <= in_valid;
            r.msb   <= in_msb;
            r.mode  <= in_mode;
            r.amt   <= in_amt;
            r.data  <= shifted;
        end
    end

    assign out_valid = r.valid;
    assign out_data  = r.data;
    assign out_amt   = r.amt;
    assign out_mode  = r.mode;
    assign out_msb   = r.msb;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined shift/rotate unit, one power-of-two step per stage.
// SHIFTER_ROR_EN builds rotate-right; otherwise mode 11 passes through.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [WIDTH-1:0]  Shift_In,
    input  logic [SHW-1:0]    Shift_Val,
    input  logic [MODE_W-1:0] Mode,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [WIDTH-1:0]  Shift_Out,
    output logic [MODE_W-1:0] Out_Mode
);

    logic             v   [SHW+1];
    logic [WIDTH-1:0] d   [SHW+1];
    logic [SHW-1:0]   a   [SHW+1];
    shift_mode_t      m   [SHW+1];
    logic             s   [SHW+1];
    logic             adv;
    logic             unused_tail;

    assign adv      = Out_Ready | ~Out_Valid;
    assign In_Ready = adv;

    assign v[0] = In_Valid;
    assign d[0] = Shift_In;
    assign m[0] = shift_mode_t'(Mode);
    assign s[0] = Shift_In[WIDTH-1];
    // Without the wrap path, ROR degenerates to a zero-amount pass
    assign a[0] = (m[0] == ROR && !ror_enabled()) ? '0 : Shift_Val;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .STEP  (1 << k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .in_valid  (v[k]),
            .in_data   (d[k]),
            .in_amt    (a[k]),
            .in_mode   (m[k]),
            .in_msb    (s[k]),
            .out_valid (v[k+1]),
            .out_data  (d[k+1]),
            .out_amt   (a[k+1]),
            .out_mode  (m[k+1]),
            .out_msb   (s[k+1])
        );
    end

    assign Out_Valid   = v[SHW];
    assign Shift_Out   = d[SHW];
    assign Out_Mode    = m[SHW];
    assign unused_tail = ^{a[SHW], s[SHW]};

endmodule
